axi4lite_init_sequencer: RTL and testbench

AXI4LITE_INIT_SEQUENCER -- requirements
Module: axi4lite_init_sequencer

---
 rtl/axi4lite_init_sequencer.sv | 134 +++++++++++++
 tb/tb_axi4lite_init_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_init_sequencer.sv
// Table-driven AXI4-Lite register initialiser: walks a registered ROM of
// write/delay entries from index 0, issuing one write per entry or waiting.
module axi4lite_init_sequencer #(
  parameter int TBL_AW = 6
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TBL_AW-1:0] err_index,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [47:0]       tbl_data,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [11:0]       m_awaddr,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [1:0]        m_bresp
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, WRITE, RESP, DELAY, FINISH} state_t;

  localparam logic [TBL_AW-1:0] IDX_MAX = '1;

  state_t            state;
  logic [TBL_AW-1:0] index;
  logic [31:0]       counter;
  logic              last_q;
  logic              aw_ok, w_ok, advance, adv_end;
  logic              unused_rsvd;

  assign m_wstrb     = 4'hF;
  assign unused_rsvd = ^tbl_data[45:44];

  always_comb begin
    aw_ok   = !m_awvalid || m_awready;
    w_ok    = !m_wvalid  || m_wready;
    advance = ((state == DECODE) && tbl_data[46] && (tbl_data[31:0] == 32'd0))
           || ((state == DELAY)  && (counter == 32'd1))
           || ((state == RESP)   && m_bvalid && (m_bresp == 2'b00));
    // A zero-length delay advances straight out of DECODE, before last_q is loaded.
    adv_end = ((state == DECODE) ? tbl_data[47] : last_q) || (index == IDX_MAX);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
      tbl_addr  <= '0;
      index     <= '0;
      counter   <= '0;
      last_q    <= 1'b0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_awaddr  <= '0;
      m_wdata   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            index    <= '0;
            tbl_addr <= '0;
            error    <= 1'b0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          last_q <= tbl_data[47];
          if (!tbl_data[46]) begin
            m_awaddr  <= tbl_data[43:32];
            m_wdata   <= tbl_data[31:0];
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
            state     <= WRITE;
          end else if (tbl_data[31:0] != 32'd0) begin
            counter <= tbl_data[31:0];
            state   <= DELAY;
          end
        end
        WRITE: begin
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            m_bready <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          if (m_bvalid) begin
            m_bready <= 1'b0;
            if (m_bresp != 2'b00) begin
              error     <= 1'b1;
              err_index <= index;
              done      <= 1'b1;
              state     <= FINISH;
            end
          end
        end
        DELAY: counter <= counter - 32'd1;
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Shared advance step for write completion, delay expiry and zero-length delays.
      if (advance) begin
        if (adv_end) begin
          done  <= 1'b1;
          state <= FINISH;
        end else begin
          index    <= index + 1'b1;
          tbl_addr <= index + 1'b1;
          state    <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_init_sequencer.sv
// Directed bench for axi4lite_init_sequencer: ROM + enable-controlled AXI slave,
// a handshake monitor, and immediate-assertion checks.
module tb_axi4lite_init_sequencer;

  logic        aclk = 1'b0;
  logic        aresetn, start, start2;
  logic        busy, done, error;
  logic [5:0]  err_index, tbl_addr;
  logic [47:0] tbl_data;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [11:0] m_awaddr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp;

  logic        busy2, done2, error2;
  logic [1:0]  err_index2, tbl_addr2;
  logic [47:0] tbl_data2;
  logic        awvalid2, wvalid2, bready2;
  logic [11:0] awaddr2;
  logic [31:0] wdata2;
  logic [3:0]  wstrb2;

  logic        aw_en, w_en, b_en, err_en;
  logic [5:0]  err_at;
  logic [47:0] rom  [64];
  logic [47:0] rom2 [4];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done2_cnt = 0;
  int aw2_cnt = 0;
  bit saw2 = 0;
  logic [1:0]  max_addr2 = '0;
  logic [11:0] last_awaddr2 = '0;
  logic [11:0] aw_addr_q[$];
  logic [31:0] w_data_q[$];
  int          aw_cyc_q[$];
  int          b_cyc_q[$];

  always #5 aclk = ~aclk;

  axi4lite_init_sequencer #(.TBL_AW(6)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy), .done(done),
    .error(error), .err_index(err_index), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
  );

  axi4lite_init_sequencer #(.TBL_AW(2)) u_dut2 (
    .aclk(aclk), .aresetn(aresetn), .start(start2), .busy(busy2), .done(done2),
    .error(error2), .err_index(err_index2), .tbl_addr(tbl_addr2), .tbl_data(tbl_data2),
    .m_awvalid(awvalid2), .m_awready(1'b1), .m_awaddr(awaddr2),
    .m_wvalid(wvalid2), .m_wready(1'b1), .m_wdata(wdata2), .m_wstrb(wstrb2),
    .m_bvalid(bready2), .m_bready(bready2), .m_bresp(2'b00)
  );

  assign m_awready = aw_en;
  assign m_wready  = w_en;
  assign m_bvalid  = m_bready & b_en;
  assign m_bresp   = (err_en && tbl_addr == err_at) ? 2'b10 : 2'b00;

  always @(posedge aclk) begin
    tbl_data  <= rom[tbl_addr];
    tbl_data2 <= rom2[tbl_addr2];
  end

  always @(posedge aclk) begin
    if (m_awvalid && m_awready) begin
      aw_addr_q.push_back(m_awaddr);
      aw_cyc_q.push_back(cyc);
    end
    if (m_wvalid && m_wready) w_data_q.push_back(m_wdata);
    if (m_bvalid && m_bready) b_cyc_q.push_back(cyc);
    if (done) done_cnt++;
    if (tbl_addr == 6'd2) saw2 = 1;
    if (done2) done2_cnt++;
    if (awvalid2) begin
      aw2_cnt++;
      last_awaddr2 = awaddr2;
    end
    if (tbl_addr2 > max_addr2) max_addr2 = tbl_addr2;
    cyc++;
  end

  function automatic logic [47:0] ent(bit last, bit op, logic [11:0] a, logic [31:0] d);
    return {last, op, 2'b00, a, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    aw_addr_q.delete();
    w_data_q.delete();
    aw_cyc_q.delete();
    b_cyc_q.delete();
    done_cnt = 0;
    saw2 = 0;
  endtask

  task automatic pulse_start();
    @(negedge aclk) start = 1'b1;
    @(negedge aclk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (!done && n < lim) begin
      @(negedge aclk);
      n++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic wait_awvalid(input string tag, input int lim);
    int n = 0;
    while (!m_awvalid && n < lim) begin
      @(negedge aclk);
      n++;
    end
    check(tag, m_awvalid, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = '0;
    rom2[0] = ent(0, 0, 12'h100, 32'h0);
    rom2[1] = ent(0, 0, 12'h104, 32'h1);
    rom2[2] = ent(0, 0, 12'h108, 32'h2);
    rom2[3] = ent(0, 0, 12'h10C, 32'h3);
    aresetn = 1'b0; start = 1'b0; start2 = 1'b0;
    aw_en = 1'b1; w_en = 1'b1; b_en = 1'b1; err_en = 1'b0; err_at = '0;

    // Reset values
    repeat (3) @(negedge aclk);
    check("rst_ctl", {busy, done, error, m_awvalid, m_wvalid, m_bready}, 6'b0);
    check("rst_idx", {err_index, tbl_addr}, 12'h0);
    check("rst_data", {m_awaddr, m_wdata}, 44'h0);
    check("rst_wstrb", m_wstrb, 4'hF);
    aresetn = 1'b1;

    // Two writes in order, immediate slave
    rom[0] = ent(0, 0, 12'h004, 32'hA5A5A5A5);
    rom[1] = ent(1, 0, 12'h00C, 32'h00000001);
    clear_mon();
    pulse_start();
    check("basic_busy", busy, 1'b1);
    wait_done("basic_done", 40);
    @(negedge aclk);
    check("basic_done_1cyc", done, 1'b0);
    check("basic_busy_low", busy, 1'b0);
    check("basic_error", error, 1'b0);
    check("basic_nwr", aw_addr_q.size(), 2);
    check("basic_addr0", aw_addr_q[0], 12'h004);
    check("basic_addr1", aw_addr_q[1], 12'h00C);
    check("basic_data0", w_data_q[0], 32'hA5A5A5A5);
    check("basic_data1", w_data_q[1], 32'h1);
    check("basic_nb", b_cyc_q.size(), 2);
    check("basic_entry_cyc", aw_cyc_q[1] - aw_cyc_q[0], 4);
    check("basic_done_cnt", done_cnt, 1);

    // awready stalled 5 cycles, wready immediate
    rom[0] = ent(1, 0, 12'h010, 32'h12345678);
    clear_mon();
    aw_en = 1'b0;
    pulse_start();
    wait_awvalid("stall_aw_rise", 10);
    check("stall_w_first", m_wvalid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("stall_aw_held", m_awvalid, 1'b1);
      check("stall_addr", m_awaddr, 12'h010);
      check("stall_w_drop", m_wvalid, 1'b0);
      check("stall_no_bready", m_bready, 1'b0);
    end
    aw_en = 1'b1;
    wait_done("stall_done", 20);
    check("stall_naw", aw_addr_q.size(), 1);
    check("stall_nw", w_data_q.size(), 1);
    check("stall_nb", b_cyc_q.size(), 1);
    check("stall_wdata", w_data_q[0], 32'h12345678);

    // Error response on entry 1
    rom[0] = ent(0, 0, 12'h020, 32'h1);
    rom[1] = ent(0, 0, 12'h024, 32'h2);
    rom[2] = ent(1, 0, 12'h028, 32'h3);
    err_en = 1'b1; err_at = 6'd1;
    @(negedge aclk);
    clear_mon();
    pulse_start();
    wait_done("err_done", 40);
    check("err_flag", error, 1'b1);
    check("err_index", err_index, 6'd1);
    check("err_nwr", aw_addr_q.size(), 2);
    @(negedge aclk);
    check("err_no_fetch2", saw2, 1'b0);
    check("err_sticky", error, 1'b1);
    check("err_busy_low", busy, 1'b0);
    err_en = 1'b0;
    clear_mon();
    pulse_start();
    check("err_cleared", error, 1'b0);
    wait_done("err_rerun_done", 40);
    check("err_rerun_nwr", aw_addr_q.size(), 3);
    check("err_rerun_flag", error, 1'b0);

    // Delay of 10 cycles, then zero delay
    rom[0] = ent(0, 0, 12'h030, 32'hAA);
    rom[1] = ent(0, 1, 12'h000, 32'd10);
    rom[2] = ent(1, 0, 12'h034, 32'hBB);
    @(negedge aclk);
    clear_mon();
    pulse_start();
    wait_done("dly10_done", 60);
    check("dly10_nwr", aw_addr_q.size(), 2);
    check("dly10_gap", aw_cyc_q[1] - b_cyc_q[0] - 1, 14);
    rom[1] = ent(0, 1, 12'h000, 32'd0);
    @(negedge aclk);
    clear_mon();
    pulse_start();
    wait_done("dly0_done", 60);
    check("dly0_gap", aw_cyc_q[1] - b_cyc_q[0] - 1, 4);
    check("dly0_addr1", aw_addr_q[1], 12'h034);

    // TBL_AW=2 with no last bits: stops at end of table
    @(negedge aclk) start2 = 1'b1;
    @(negedge aclk) start2 = 1'b0;
    for (int n = 0; n < 60 && !done2; n++) @(negedge aclk);
    check("end_done", done2, 1'b1);
    repeat (3) @(negedge aclk);
    check("end_nwr", aw2_cnt, 4);
    check("end_max_addr", max_addr2, 2'd3);
    check("end_last_addr", last_awaddr2, 12'h10C);
    check("end_done_cnt", done2_cnt, 1);
    check("end_busy_low", busy2, 1'b0);

    // Reset asserted during WRITE
    rom[0] = ent(0, 0, 12'h040, 32'h11);
    rom[1] = ent(1, 0, 12'h044, 32'h22);
    aw_en = 1'b0;
    clear_mon();
    pulse_start();
    wait_awvalid("rstw_in_write", 10);
    #2 aresetn = 1'b0;
    #1;
    check("rstw_valids", {m_awvalid, m_wvalid, m_bready}, 3'b0);
    check("rstw_ctl", {busy, done, error}, 3'b0);
    check("rstw_regs", {m_awaddr, m_wdata, tbl_addr}, 50'h0);
    @(negedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    aw_en = 1'b1;
    repeat (5) @(negedge aclk);
    check("rstw_no_done", done_cnt, 0);
    check("rstw_idle", busy, 1'b0);
    clear_mon();
    pulse_start();
    wait_done("rstw_rerun_done", 40);
    check("rstw_rerun_addr0", aw_addr_q[0], 12'h040);
    check("rstw_rerun_nwr", aw_addr_q.size(), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
